// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register family:
// mode codes and the counter-width helper.
package usr_pkg;

   localparam logic [2:0] USR_HOLD  = 3'b000;
   localparam logic [2:0] USR_LOAD  = 3'b001;
   localparam logic [2:0] USR_SHL   = 3'b010;
   localparam logic [2:0] USR_SHR   = 3'b011;
   localparam logic [2:0] USR_ROTL  = 3'b100;
   localparam logic [2:0] USR_ROTR  = 3'b101;
   localparam logic [2:0] USR_CLEAR = 3'b110;
   localparam logic [2:0] USR_RSVD  = 3'b111;

   // Bits needed to hold a shift count in 0..width.
   function automatic int usr_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/usr_shift_cnt.sv
// Wrap counter: counts inc pulses modulo WIDTH and raises a one-cycle
// registered wrap flag on the edge that rolls the count back to zero.
module usr_shift_cnt
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          inc,
   input  logic                          clr,
   output logic [usr_cnt_w(WIDTH)-1:0]   cnt,
   output logic                          wrap
);

   localparam int CW = usr_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Count register; wrap drops back to 0 on every edge that does not wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            cnt <= '0;
         end else if (inc) begin
            if (cnt == LAST) begin
               cnt  <= '0;
               wrap <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold, parallel load, logical shift and rotate in
// both directions, clear. Tracks shifts per word and flags each full word.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [2:0]                    mode,
   input  logic [WIDTH-1:0]              d,
   input  logic                          sin_l,
   input  logic                          sin_r,
   output logic [WIDTH-1:0]              q,
   output logic                          sout_l,
   output logic                          sout_r,
   output logic [usr_cnt_w(WIDTH)-1:0]   cnt,
   output logic                          word_done
);

   logic is_shift;
   logic is_clr;

   // Classify the current mode: moves advance the counter, load/clear restart it.
   always_comb begin
      is_shift = 1'b0;
      is_clr   = 1'b0;
      if (en) begin
         case (mode)
            USR_SHL, USR_SHR, USR_ROTL, USR_ROTR: is_shift = 1'b1;
            USR_LOAD, USR_CLEAR:                  is_clr   = 1'b1;
            default: ;
         endcase
      end
   end

   // Data path: reset beats enable, enable beats mode; reserved acts as hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         case (mode)
            USR_LOAD:  q <= d;
            USR_SHL:   q <= {q[WIDTH-2:0], sin_l};
            USR_SHR:   q <= {sin_r, q[WIDTH-1:1]};
            USR_ROTL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
            USR_ROTR:  q <= {q[0], q[WIDTH-1:1]};
            USR_CLEAR: q <= RST_VAL;
            default:   q <= q;
         endcase
      end
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

   usr_shift_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (is_shift),
      .clr  (is_clr),
      .cnt  (cnt),
      .wrap (word_done)
   );

endmodule
